// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction fields into 32-bit words and streams them into imem via a FIFO.
module instr_encoder_loader #(
   parameter int AW        = 16,
   parameter int DEPTH     = 4,
   parameter int ADDR_STEP = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_class,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_rs1,
   input  logic [4:0]    in_rs2,
   input  logic [4:0]    in_rs3,
   input  logic [11:0]   in_imm,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   input  logic          imem_stall,
   output logic          busy,
   output logic          done,
   output logic          err_class,
   output logic [15:0]   wr_count
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, nxt;
   logic [31:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0] cnt;
   logic full, empty, hs, push, pop, drained;
   logic [10:0] dec;
   logic vld, urd, urs1, urs2, urs3, uimm;
   logic [4:0] op;
   logic [31:0] word;
   // dec = {valid, opcode, uses rd/rs1/rs2/rs3/imm}
   always_comb begin
      case (in_class)
         4'd0:    dec = {1'b1, 5'b01101, 5'b11110};
         4'd1:    dec = {1'b1, 5'b00011, 5'b11100};
         4'd2:    dec = {1'b1, 5'b00001, 5'b11000};
         4'd3:    dec = {1'b1, 5'b00101, 5'b11000};
         4'd4:    dec = {1'b1, 5'b10111, 5'b11001};
         4'd5:    dec = {1'b1, 5'b10001, 5'b01101};
         4'd6:    dec = {1'b1, 5'b01010, 5'b01101};
         4'd7:    dec = {1'b1, 5'b11101, 5'b11001};
         4'd8:    dec = {1'b1, 5'b01111, 5'b11001};
         4'd9:    dec = {1'b1, 5'b11110, 5'b10001};
         default: dec = '0;
      endcase
   end
   assign {vld, op, urd, urs1, urs2, urs3, uimm} = dec;
   assign word = {27'b0, op}
               | (urd  ? {22'b0, in_rd,  5'b0}  : 32'b0)
               | (urs1 ? {17'b0, in_rs1, 10'b0} : 32'b0)
               | (urs2 ? {12'b0, in_rs2, 15'b0} : 32'b0)
               | (urs3 ? {7'b0,  in_rs3, 20'b0} : 32'b0)
               | (uimm ? {in_imm, 20'b0}        : 32'b0);
   assign full    = cnt == (PW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign hs      = in_valid && in_ready;
   assign push    = hs && vld;
   assign imem_we = !empty && !imem_stall;
   assign pop     = imem_we;
   assign imem_wdata = empty ? 32'b0 : mem[rp];
   // FIFO becomes empty by the end of this cycle
   assign drained = empty || (cnt == (PW+1)'(1) && pop);
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= word;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? RUN : IDLE;
         RUN:     nxt = (hs && in_last) ? DRAIN : RUN;
         DRAIN:   nxt = drained ? IDLE : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      in_ready = (state == RUN) && !full;
      busy     = state != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_addr <= '0;
         wr_count  <= '0;
         done      <= 1'b0;
         err_class <= 1'b0;
      end else begin
         done      <= (state == DRAIN) && (nxt == IDLE);
         err_class <= hs && !vld;
         if (state == IDLE && start) begin
            imem_addr <= base_addr;
            wr_count  <= '0;
         end else if (pop) begin
            imem_addr <= imem_addr + AW'(ADDR_STEP);
            wr_count  <= wr_count + 16'(wr_count != 16'hFFFF);
         end
      end
   end
endmodule
